// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// debounces press and release, and reports each accepted press as a hex code
// with a one-cycle key_valid pulse.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    HELD,
    DEB_RELEASE
  } state_e;

  state_e        state_q,     state_d;
  logic [1:0]    col_idx_q,   col_idx_d;
  logic [1:0]    row_idx_q,   row_idx_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [3:0]    col_n_q,     col_n_d;
  logic [3:0]    key_q,       key_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q,  key_held_d;
  logic [3:0]    sync1_q;
  logic [3:0]    rs_q;

  // Active-low one-hot decode of a 2-bit index (column drive / row pattern).
  function automatic logic [3:0] low_onehot(input logic [1:0] idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

  // True when exactly one of the four active-low rows is asserted.
  function automatic logic single_low(input logic [3:0] v);
    logic r;
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // Index of the low row; only meaningful when single_low() holds.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] r;
    case (v)
      4'b1110: r = 2'd0;
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  // Physical keypad legend: rows 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] r;
    case ({row, col})
      4'b00_00: r = 4'h1;
      4'b00_01: r = 4'h2;
      4'b00_10: r = 4'h3;
      4'b00_11: r = 4'hA;
      4'b01_00: r = 4'h4;
      4'b01_01: r = 4'h5;
      4'b01_10: r = 4'h6;
      4'b01_11: r = 4'hB;
      4'b10_00: r = 4'h7;
      4'b10_01: r = 4'h8;
      4'b10_10: r = 4'h9;
      4'b10_11: r = 4'hC;
      4'b11_00: r = 4'hE;
      4'b11_01: r = 4'h0;
      4'b11_10: r = 4'hF;
      default:  r = 4'hD;
    endcase
    return r;
  endfunction

  // Next-state logic for the scan / debounce / hold sequence.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    unique case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (single_low(rs_q)) begin
            row_idx_d = low_index(rs_q);
            state_d   = DEB_PRESS;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DEB_PRESS: begin
        if (rs_q == low_onehot(row_idx_q)) begin
          if (cnt_q == DEB_LAST) begin
            cnt_d       = '0;
            key_d       = key_map(row_idx_q, col_idx_q);
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            state_d     = HELD;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = SCAN;
        end
      end

      HELD: begin
        // The first high cycle already counts toward the release debounce.
        if (rs_q[row_idx_q]) begin
          cnt_d   = CNT_ONE;
          state_d = DEB_RELEASE;
        end
      end

      DEB_RELEASE: begin
        if (rs_q[row_idx_q]) begin
          if (cnt_q == DEB_LAST) begin
            cnt_d      = '0;
            key_held_d = 1'b0;
            col_idx_d  = col_idx_q + 2'd1;
            state_d    = SCAN;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = '0;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = SCAN;
      end
    endcase

    col_n_d = low_onehot(col_idx_d);
  end

  // State, outputs and the two-flop row synchronizer, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= SCAN;
      col_idx_q   <= '0;
      row_idx_q   <= '0;
      cnt_q       <= '0;
      col_n_q     <= 4'b1110;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      sync1_q     <= '1;
      rs_q        <= '1;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      cnt_q       <= cnt_d;
      col_n_q     <= col_n_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      sync1_q     <= row_n;
      rs_q        <= sync1_q;
    end
  end

  assign col_n     = col_n_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
